uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_if.sv | 31 +++
 rtl/uart_rx_sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 153 +++++++++++++++
 tb/tb_uart_rx.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, oversampling constants and the
// receiver/transmitter state encoding.
package uart_pkg;

    localparam int OVERSAMPLE    = 16;
    localparam int MID_SAMPLE    = 7;
    localparam int DATA_BITS     = 8;
    localparam int CLKS_PER_TICK = 28;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Host-side byte interface of the UART receiver: received byte, status flags
// and the consumer acknowledge.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 rdy;
    logic                 rdy_clr;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output data,
        output rdy,
        output frame_err,
        output overrun,
        output busy,
        input  rdy_clr
    );

    modport slave (
        input  data,
        input  rdy,
        input  frame_err,
        input  overrun,
        input  busy,
        output rdy_clr
    );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Flop-chain synchronizer for an asynchronous input that idles high; every
// stage resets to 1 so reset never fakes a falling edge.
module sync_2ff #(
    parameter int STAGES = 2
) (
    input  logic clk_50m,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling 8N1 UART receiver: recovers bytes from rx and holds them
// behind a sticky rdy flag with frame-error and overrun reporting.
module uart_rx #(
    parameter int DATA_BITS  = uart_pkg::DATA_BITS,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int MID_SAMPLE = uart_pkg::MID_SAMPLE
) (
    input  logic      clk_50m,
    input  logic      rst,
    input  logic      rxclk_en,
    input  logic      rx,
    uart_rx_if.master host
);
    import uart_pkg::*;

    localparam int                CNT_W    = $clog2(OVERSAMPLE);
    localparam int                IDX_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  MID_CNT  = CNT_W'(MID_SAMPLE);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;

    uart_state_t          state_reg,     state_next;
    logic [CNT_W-1:0]     cnt_reg,       cnt_next;
    logic [IDX_W-1:0]     bit_idx_reg,   bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg,     shift_next;
    logic [DATA_BITS-1:0] data_reg,      data_next;
    logic                 rdy_reg,       rdy_next;
    logic                 frame_err_reg, frame_err_next;
    logic                 overrun_reg,   overrun_next;
    logic                 busy_reg,      busy_next;

    sync_2ff #(
        .STAGES (2)
    ) u_sync (
        .clk_50m (clk_50m),
        .rst     (rst),
        .d       (rx),
        .q       (rx_s)
    );

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            rdy_reg       <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            rdy_reg       <= rdy_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        data_next      = data_reg;
        rdy_next       = rdy_reg;
        frame_err_next = frame_err_reg;
        overrun_next   = overrun_reg;

        // The acknowledge acts every cycle; a completing good frame below overrides it.
        if (host.rdy_clr) begin
            rdy_next     = 1'b0;
            overrun_next = 1'b0;
        end

        if (rxclk_en) begin
            case (state_reg)
                IDLE: begin
                    if (!rx_s) begin
                        state_next = START;
                        cnt_next   = '0;
                    end
                end

                START: begin
                    if (cnt_reg == MID_CNT) begin
                        cnt_next = '0;
                        if (!rx_s) begin
                            state_next   = DATA;
                            bit_idx_next = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end

                DATA: begin
                    // Counter wraps 15 -> 0 so the next sample lands a full bit later.
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_idx_reg == LAST_IDX) begin
                            state_next = STOP;
                        end else begin
                            bit_idx_next = bit_idx_reg + 1'b1;
                        end
                    end
                end

                STOP: begin
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        if (rx_s) begin
                            data_next      = shift_reg;
                            rdy_next       = 1'b1;
                            frame_err_next = 1'b0;
                            if (rdy_reg && !host.rdy_clr) begin
                                overrun_next = 1'b1;
                            end
                        end else begin
                            frame_err_next = 1'b1;
                        end
                    end
                end

                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end

        busy_next = (state_next != IDLE);
    end

    assign host.data      = data_reg;
    assign host.rdy       = rdy_reg;
    assign host.frame_err = frame_err_reg;
    assign host.overrun   = overrun_reg;
    assign host.busy      = busy_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised and directed frame bench for uart_rx; a frame-level model predicts
// the host-side outputs during every idle stretch between frames.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_CLKS   = OVERSAMPLE * CLKS_PER_TICK;
    localparam int FRAME_CLKS = (DATA_BITS + 2) * BIT_CLKS;
    localparam int STOP_AT    = (DATA_BITS + 1) * BIT_CLKS;

    logic clk_50m  = 1'b0;
    logic rst      = 1'b1;
    logic rxclk_en = 1'b0;
    logic rx       = 1'b1;
    int   tick_cnt = 0;

    uart_rx_if host ();

    uart_rx dut (
        .clk_50m  (clk_50m),
        .rst      (rst),
        .rxclk_en (rxclk_en),
        .rx       (rx),
        .host     (host)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] m_data   = '0;
    logic       m_rdy    = 1'b0;
    logic       m_fe     = 1'b0;
    logic       m_ov     = 1'b0;
    bit         check_en = 1'b0;
    int         last_rise;
    logic [1:0] last_busy_pair;
    logic [1:0] last_snap;
    int         ref_rise;

    always #10 clk_50m = ~clk_50m;

    // Baud-rate strobe: one pulse every CLKS_PER_TICK cycles.
    always @(posedge clk_50m) begin
        if (tick_cnt == CLKS_PER_TICK - 1) begin
            tick_cnt <= 0;
            rxclk_en <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1;
            rxclk_en <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [11:0] outs();
        return {host.busy, host.overrun, host.frame_err, host.rdy, host.data};
    endfunction

    function automatic logic [11:0] model_outs();
        return {1'b0, m_ov, m_fe, m_rdy, m_data};
    endfunction

    always @(posedge clk_50m) begin
        #2;
        if (check_en) check("idle_outputs", 32'(outs()), 32'(model_outs()));
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    task automatic pulse_clr();
        host.rdy_clr = 1'b1;
        m_rdy = 1'b0;
        m_ov  = 1'b0;
        @(negedge clk_50m);
        host.rdy_clr = 1'b0;
    endtask

    // phase < 0 starts immediately (back-to-back); clr_cyc >= 0 pulses rdy_clr at that cycle.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int phase,
                              input int clr_cyc, input bit end_clr);
        logic prev_rdy, prev_busy, rdy0;
        bit   acked;
        int   bi;
        if (phase >= 0) begin
            for (int i = 0; i < CLKS_PER_TICK; i++) begin
                if (tick_cnt == phase) break;
                @(negedge clk_50m);
            end
        end
        check_en  = 1'b0;
        acked     = 1'b0;
        last_rise = -1;
        rdy0      = host.rdy;
        prev_rdy  = host.rdy;
        prev_busy = host.busy;
        for (int k = 0; k < FRAME_CLKS; k++) begin
            bi = k / BIT_CLKS;
            if (bi == 0) rx = 1'b0;
            else if (bi > DATA_BITS) rx = stop_ok;
            else rx = b[3'(bi - 1)];
            host.rdy_clr = (k == clr_cyc) || (end_clr && k == STOP_AT + 400);
            if (k == clr_cyc) acked = 1'b1;
            if (end_clr && k == STOP_AT + 400) begin
                m_rdy = 1'b0;
                m_ov  = 1'b0;
            end
            @(negedge clk_50m);
            if (last_rise < 0 && !prev_rdy && host.rdy) begin
                last_rise      = k + 1;
                last_busy_pair = {prev_busy, host.busy};
            end
            if (k == clr_cyc) last_snap = {host.rdy, host.overrun};
            prev_rdy  = host.rdy;
            prev_busy = host.busy;
            if (k == STOP_AT + 300) begin
                if (stop_ok) begin
                    if (acked) m_ov = 1'b0;
                    else if (m_rdy) m_ov = 1'b1;
                    m_rdy  = 1'b1;
                    m_data = b;
                    m_fe   = 1'b0;
                    check_en = 1'b1;
                end else begin
                    if (acked) begin
                        m_rdy = 1'b0;
                        m_ov  = 1'b0;
                    end
                    m_fe = 1'b1;
                end
            end
        end
        host.rdy_clr = 1'b0;
        rx = 1'b1;
        if (!stop_ok) begin
            cycles(BIT_CLKS);
            check_en = 1'b1;
        end
        if (stop_ok && !rdy0 && clr_cyc < 0)
            check("rdy_latency", 32'(last_rise >= 4250 && last_rise <= 4300), 32'd1);
        $display("frame 0x%02h stop=%0d -> data=0x%02h rdy=%0b fe=%0b ov=%0b rise=%0d",
                 b, stop_ok, host.data, host.rdy, host.frame_err, host.overrun, last_rise);
    endtask

    initial begin
        repeat (95000) @(posedge clk_50m);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "watchdog");
    end

    initial begin
        host.rdy_clr = 1'b0;
        cycles(5);
        rst = 1'b0;
        check_en = 1'b1;
        cycles(1);
        check("reset_state", 32'(outs()), 32'd0);

        // Single frame
        send_frame(8'h55, 1'b1, 3, -1, 1'b0);
        check("x55_data", 32'(host.data), 32'h55);
        check("x55_flags", 32'({host.rdy, host.frame_err, host.overrun}), 32'b100);
        check("x55_busy_falls_with_rdy", 32'(last_busy_pair), 32'b10);

        // Back-to-back with an acknowledge between
        pulse_clr();
        send_frame(8'hA3, 1'b1, 17, -1, 1'b1);
        send_frame(8'h0F, 1'b1, -1, -1, 1'b0);
        check("b2b_data", 32'(host.data), 32'h0F);
        check("b2b_no_overrun", 32'({host.rdy, host.overrun}), 32'b10);

        // Overrun
        pulse_clr();
        send_frame(8'h81, 1'b1, 9, -1, 1'b0);
        send_frame(8'h7E, 1'b1, -1, -1, 1'b0);
        check("ovr_data", 32'(host.data), 32'h7E);
        check("ovr_flags", 32'({host.rdy, host.overrun}), 32'b11);
        pulse_clr();
        cycles(1);
        check("ovr_cleared", 32'({host.rdy, host.overrun}), 32'b00);

        // Framing error keeps the previous byte
        send_frame(8'hC4, 1'b0, 21, -1, 1'b0);
        check("fe_set", 32'(host.frame_err), 32'd1);
        check("fe_rdy_low", 32'(host.rdy), 32'd0);
        check("fe_data_kept", 32'(host.data), 32'h7E);
        send_frame(8'h12, 1'b1, 5, -1, 1'b0);
        check("after_fe_data", 32'(host.data), 32'h12);
        check("after_fe_clear", 32'(host.frame_err), 32'd0);

        // Short glitch is rejected at the start-bit mid check
        pulse_clr();
        check_en = 1'b0;
        rx = 1'b0;
        cycles(80);
        check("glitch_busy", 32'(host.busy), 32'd1);
        cycles(20);
        rx = 1'b1;
        cycles(BIT_CLKS);
        check_en = 1'b1;
        check("glitch_ignored", 32'({host.busy, host.rdy, host.frame_err}), 32'b000);
        $display("glitch 100 cycles -> busy=%0b rdy=%0b fe=%0b", host.busy, host.rdy, host.frame_err);

        // Reset in the middle of a frame
        send_frame(8'h99, 1'b1, 0, -1, 1'b0);
        check_en = 1'b0;
        rx = 1'b0;
        cycles(BIT_CLKS);
        rx = 1'b1;
        cycles(3 * BIT_CLKS);
        check("midframe_busy", 32'(host.busy), 32'd1);
        rst = 1'b1;
        m_data = '0; m_rdy = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        cycles(1);
        rst = 1'b0;
        check_en = 1'b1;
        cycles(2);
        check("midframe_reset", 32'(outs()), 32'd0);
        $display("reset mid-frame -> outs=0x%03h", outs());
        cycles(100);
        send_frame(8'h3C, 1'b1, 11, -1, 1'b0);
        check("post_reset_data", 32'(host.data), 32'h3C);
        ref_rise = last_rise;

        // rdy_clr on the very edge that completes the next frame
        send_frame(8'h5A, 1'b1, 11, ref_rise - 1, 1'b0);
        check("coincide_snap", 32'(last_snap), 32'b10);
        check("coincide_data", 32'(host.data), 32'h5A);

        // Randomised frames
        for (int r = 0; r < 3; r++) begin
            logic [7:0] rb;
            bit         ok;
            rb = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            send_frame(rb, ok, int'($urandom_range(0, CLKS_PER_TICK - 1)), -1,
                       $urandom_range(0, 1) == 1);
        end
        cycles(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
